// File: rtl/cpu_controller.sv
// cpu_controller: Moore sequencer for the single-cycle-resource CPU datapath.
// It steps through fetch, decode and execute until the instruction in IR is
// HALT, or until Clr is asserted.
//
// Ports:
//   Clock       in   system clock, rising edge
//   Clr         in   synchronous active-high reset
//   IR          in   instruction register contents (opcode = IR[IW-1:IW-4])
//   PC_clr      out  clear program counter
//   PC_up       out  increment program counter
//   IR_ld       out  load IR from instruction memory
//   D_addr      out  data-memory address
//   D_wr        out  data-memory write enable
//   RF_s        out  register-file write-data select (1 = memory, 0 = ALU)
//   RF_W_addr   out  register-file write address
//   RF_W_en     out  register-file write enable
//   RF_Ra_addr  out  register-file read port A address
//   RF_Rb_addr  out  register-file read port B address
//   ALU_s0      out  ALU operation (000 pass A, 001 add, 010 sub)
//   state       out  current state code (debug)
module cpu_controller #(
   parameter int unsigned IW  = 16,
   parameter int unsigned DAW = 8,
   parameter int unsigned RAW = 4
) (
   input  logic           Clock,
   input  logic           Clr,
   input  logic [IW-1:0]  IR,
   output logic           PC_clr,
   output logic           PC_up,
   output logic           IR_ld,
   output logic [DAW-1:0] D_addr,
   output logic           D_wr,
   output logic           RF_s,
   output logic [RAW-1:0] RF_W_addr,
   output logic           RF_W_en,
   output logic [RAW-1:0] RF_Ra_addr,
   output logic [RAW-1:0] RF_Rb_addr,
   output logic [2:0]     ALU_s0,
   output logic [3:0]     state
);

   localparam int unsigned OPW = 4;
   localparam int unsigned FW  = 4;
   localparam int unsigned AW  = 8;

   localparam logic [3:0] S_INIT   = 4'd0;
   localparam logic [3:0] S_FETCH  = 4'd1;
   localparam logic [3:0] S_DECODE = 4'd2;
   localparam logic [3:0] S_NOOP   = 4'd3;
   localparam logic [3:0] S_LOAD_A = 4'd4;
   localparam logic [3:0] S_LOAD_B = 4'd5;
   localparam logic [3:0] S_STORE  = 4'd6;
   localparam logic [3:0] S_ADD    = 4'd7;
   localparam logic [3:0] S_SUB    = 4'd8;
   localparam logic [3:0] S_HALT   = 4'd9;

   localparam logic [OPW-1:0] OP_NOOP  = 4'b0000;
   localparam logic [OPW-1:0] OP_STORE = 4'b0001;
   localparam logic [OPW-1:0] OP_LOAD  = 4'b0010;
   localparam logic [OPW-1:0] OP_ADD   = 4'b0011;
   localparam logic [OPW-1:0] OP_SUB   = 4'b0100;
   localparam logic [OPW-1:0] OP_HALT  = 4'b0101;

   localparam logic [2:0] ALU_ADD = 3'b001;
   localparam logic [2:0] ALU_SUB = 3'b010;

   logic [3:0]     state_q;
   logic [3:0]     state_d;
   logic [OPW-1:0] opcode;
   logic [FW-1:0]  fld_a;     // IR[11:8]
   logic [FW-1:0]  fld_b;     // IR[7:4]
   logic [FW-1:0]  fld_d;     // IR[3:0]
   logic [AW-1:0]  ld_addr;   // IR[11:4]
   logic [AW-1:0]  st_addr;   // IR[7:0]

   // Instruction field extraction
   assign opcode  = IR[IW-1 -: OPW];
   assign fld_a   = IR[IW-OPW-1 -: FW];
   assign fld_b   = IR[IW-OPW-FW-1 -: FW];
   assign fld_d   = IR[FW-1:0];
   assign ld_addr = IR[IW-OPW-1 -: AW];
   assign st_addr = IR[AW-1:0];

   assign state = state_q;

   // State register with synchronous reset
   always_ff @(posedge Clock) begin
      if (Clr) state_q <= S_INIT;
      else     state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_INIT:   state_d = S_FETCH;
         S_FETCH:  state_d = S_DECODE;
         S_DECODE: begin
            case (opcode)
               OP_NOOP:  state_d = S_NOOP;
               OP_STORE: state_d = S_STORE;
               OP_LOAD:  state_d = S_LOAD_A;
               OP_ADD:   state_d = S_ADD;
               OP_SUB:   state_d = S_SUB;
               OP_HALT:  state_d = S_HALT;
               default:  state_d = S_NOOP;   // unused opcodes behave as NOOP
            endcase
         end
         S_NOOP:   state_d = S_FETCH;
         S_LOAD_A: state_d = S_LOAD_B;
         S_LOAD_B: state_d = S_FETCH;
         S_STORE:  state_d = S_FETCH;
         S_ADD:    state_d = S_FETCH;
         S_SUB:    state_d = S_FETCH;
         S_HALT:   state_d = S_HALT;
         default:  state_d = S_INIT;
      endcase
   end

   // Moore output decode; Clr masks every strobe that could change state
   always_comb begin
      PC_clr     = 1'b0;
      PC_up      = 1'b0;
      IR_ld      = 1'b0;
      D_addr     = '0;
      D_wr       = 1'b0;
      RF_s       = 1'b0;
      RF_W_addr  = '0;
      RF_W_en    = 1'b0;
      RF_Ra_addr = '0;
      RF_Rb_addr = '0;
      ALU_s0     = 3'b000;

      case (state_q)
         S_INIT: PC_clr = 1'b1;
         S_FETCH: begin
            IR_ld = 1'b1;
            PC_up = 1'b1;
         end
         S_LOAD_A: begin
            D_addr    = DAW'(ld_addr);
            RF_s      = 1'b1;
            RF_W_addr = RAW'(fld_d);
         end
         // Memory read data is valid here, one cycle after the address
         S_LOAD_B: begin
            D_addr    = DAW'(ld_addr);
            RF_s      = 1'b1;
            RF_W_addr = RAW'(fld_d);
            RF_W_en   = 1'b1;
         end
         S_STORE: begin
            D_addr     = DAW'(st_addr);
            RF_Ra_addr = RAW'(fld_a);
            D_wr       = 1'b1;
         end
         S_ADD, S_SUB: begin
            RF_Ra_addr = RAW'(fld_a);
            RF_Rb_addr = RAW'(fld_b);
            ALU_s0     = (state_q == S_ADD) ? ALU_ADD : ALU_SUB;
            RF_W_addr  = RAW'(fld_d);
            RF_W_en    = 1'b1;
         end
         default: ;
      endcase

      if (Clr) begin
         PC_clr  = 1'b1;
         PC_up   = 1'b0;
         IR_ld   = 1'b0;
         D_wr    = 1'b0;
         RF_W_en = 1'b0;
      end
   end

endmodule

// File: tb/tb_cpu_controller.sv
// tb_cpu_controller: directed plus randomized instruction stream for
// cpu_controller. Each instruction is expanded by a small reference model
// into the list of cycles it should occupy, with the outputs expected in each.
module tb_cpu_controller;

   logic        Clock;
   logic        Clr;
   logic [15:0] IR;
   logic        PC_clr, PC_up, IR_ld, D_wr, RF_s, RF_W_en;
   logic [7:0]  D_addr;
   logic [3:0]  RF_W_addr, RF_Ra_addr, RF_Rb_addr, state;
   logic [2:0]  ALU_s0;

   cpu_controller dut (
      .Clock      (Clock),
      .Clr        (Clr),
      .IR         (IR),
      .PC_clr     (PC_clr),
      .PC_up      (PC_up),
      .IR_ld      (IR_ld),
      .D_addr     (D_addr),
      .D_wr       (D_wr),
      .RF_s       (RF_s),
      .RF_W_addr  (RF_W_addr),
      .RF_W_en    (RF_W_en),
      .RF_Ra_addr (RF_Ra_addr),
      .RF_Rb_addr (RF_Rb_addr),
      .ALU_s0     (ALU_s0),
      .state      (state)
   );

   typedef struct packed {
      logic [3:0] st;
      logic       pc_clr;
      logic       pc_up;
      logic       ir_ld;
      logic [7:0] d_addr;
      logic       d_wr;
      logic       rf_s;
      logic [3:0] wa;
      logic       wen;
      logic [3:0] ra;
      logic [3:0] rb;
      logic [2:0] alu;
   } obs_t;

   int   n_tests = 0;
   int   n_fail  = 0;
   int   up_cnt  = 0;
   obs_t exp_q[$];

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   // Independent count of PC increments, sampled mid-cycle
   always @(negedge Clock) if (PC_up === 1'b1) up_cnt <= up_cnt + 1;

   function automatic obs_t blank(input logic [3:0] st);
      obs_t o;
      o    = '0;
      o.st = st;
      return o;
   endfunction

   function automatic obs_t with_clr(input obs_t e);
      obs_t o;
      o        = e;
      o.pc_clr = 1'b1;
      o.pc_up  = 1'b0;
      o.ir_ld  = 1'b0;
      o.d_wr   = 1'b0;
      o.wen    = 1'b0;
      return o;
   endfunction

   function automatic obs_t sample();
      obs_t o;
      o = '{st: state, pc_clr: PC_clr, pc_up: PC_up, ir_ld: IR_ld,
            d_addr: D_addr, d_wr: D_wr, rf_s: RF_s, wa: RF_W_addr,
            wen: RF_W_en, ra: RF_Ra_addr, rb: RF_Rb_addr, alu: ALU_s0};
      return o;
   endfunction

   // Reference: the cycles one instruction occupies, from its FETCH onward
   function automatic void expand(input logic [15:0] ir);
      obs_t f, e, e2;
      f       = blank(4'd1);
      f.ir_ld = 1'b1;
      f.pc_up = 1'b1;
      exp_q.push_back(f);
      exp_q.push_back(blank(4'd2));
      case (ir[15:12])
         4'h1: begin
            e        = blank(4'd6);
            e.d_addr = ir[7:0];
            e.ra     = ir[11:8];
            e.d_wr   = 1'b1;
            exp_q.push_back(e);
         end
         4'h2: begin
            e        = blank(4'd4);
            e.d_addr = ir[11:4];
            e.rf_s   = 1'b1;
            e.wa     = ir[3:0];
            e2       = e;
            e2.st    = 4'd5;
            e2.wen   = 1'b1;
            exp_q.push_back(e);
            exp_q.push_back(e2);
         end
         4'h3, 4'h4: begin
            e     = blank((ir[15:12] == 4'h3) ? 4'd7 : 4'd8);
            e.ra  = ir[11:8];
            e.rb  = ir[7:4];
            e.wa  = ir[3:0];
            e.wen = 1'b1;
            e.alu = (ir[15:12] == 4'h3) ? 3'b001 : 3'b010;
            exp_q.push_back(e);
         end
         4'h5: exp_q.push_back(blank(4'd9));
         default: exp_q.push_back(blank(4'd3));
      endcase
   endfunction

   task automatic step();
      @(posedge Clock);
      #1;
   endtask

   task automatic check(input string tag, input obs_t e);
      obs_t o;
      o = sample();
      n_tests++;
      assert (o === e) else begin
         n_fail++;
         $error("FAIL %s: observed=%h expected=%h", tag, o, e);
      end
   endtask

   // Run one non-HALT instruction from its FETCH to the next FETCH
   task automatic run_instr(input logic [15:0] ir, input string tag);
      exp_q.delete();
      expand(ir);
      for (int i = 0; i < exp_q.size(); i++) begin
         check(tag, exp_q[i]);
         if (i == 0) IR = ir;   // IR is loaded at the end of FETCH
         step();
      end
   endtask

   initial begin
      logic [15:0] r;
      obs_t        init_e;
      int          up0;

      init_e        = blank(4'd0);
      init_e.pc_clr = 1'b1;

      // Reset held two cycles, then released
      Clr = 1'b1;
      IR  = 16'h0000;
      step();
      check("reset_c1", init_e);
      step();
      check("reset_c2", init_e);
      Clr = 1'b0;
      #1;
      check("init_after_reset", init_e);
      step();

      run_instr(16'h2153, "load_r3");
      run_instr(16'h1A07, "store_r10");
      run_instr(16'h3124, "add");
      run_instr(16'h4124, "sub");
      run_instr(16'hF000, "illegal_f");

      // Randomized stream excluding HALT
      for (int n = 0; n < 40; n++) begin
         r = 16'($urandom);
         if (r[15:12] == 4'h5) r[15:12] = 4'h2;
         run_instr(r, "random");
      end

      // Clr during LOAD_B suppresses the register write
      exp_q.delete();
      expand(16'h2153);
      for (int i = 0; i < 4; i++) begin
         check("clr_load_pre", exp_q[i]);
         if (i == 0) IR = 16'h2153;
         if (i < 3) step();
      end
      Clr = 1'b1;
      #1;
      check("clr_load_b", with_clr(exp_q[3]));
      step();
      Clr = 1'b0;
      #1;
      check("clr_load_init", init_e);
      step();

      // 130 NOOP-class instructions: PC wraps, increments once each
      up0 = up_cnt;
      for (int n = 0; n < 130; n++) begin
         r        = 16'($urandom);
         r[15:12] = (n % 2 == 0) ? 4'h0 : 4'($urandom_range(6, 15));
         run_instr(r, "noop_run");
      end
      n_tests++;
      assert ((up_cnt - up0) === 130) else begin
         n_fail++;
         $error("FAIL pc_up_count: observed=%0d expected=130", up_cnt - up0);
      end

      // HALT holds for 20 cycles regardless of IR changes
      exp_q.delete();
      expand(16'h5000);
      check("halt_fetch", exp_q[0]);
      IR = 16'h5000;
      step();
      check("halt_decode", exp_q[1]);
      step();
      for (int n = 0; n < 20; n++) begin
         check("halt_hold", blank(4'd9));
         if (n >= 10) IR = 16'($urandom);
         step();
      end

      // Clr releases HALT
      Clr = 1'b1;
      #1;
      check("clr_halt", with_clr(blank(4'd9)));
      step();
      check("clr_halt_init", init_e);
      step();
      check("clr_held_init", init_e);
      Clr = 1'b0;
      #1;
      step();
      run_instr(16'h3ABC, "add_after_halt");
      exp_q.delete();
      expand(16'h0000);
      check("fetch_final", exp_q[0]);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
